// File: rtl/nibble_serial_adder.sv
// Wide add controller: drives an external 4-bit adder one nibble per clock.
// Ports: in_* operand handshake, add_* adder drive/return, out_* result handshake.
// Option: NIBBLE_SERIAL_ADDER_SUB_EN adds op_sub (A-B when op_sub=1).
module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES,
  localparam int IW = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic         op_sub,
`endif
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_s,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_c;
  logic [W-1:0]  r_sum;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_sum_o;
  logic          r_cout_o;

  logic          w_last;
  logic          w_sub;
  logic [W-1:0]  w_sum_nxt;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign w_sub = op_sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_last = (r_idx == IW'(NIBBLES - 1));
  assign busy   = (r_state != S_IDLE);
  assign sum    = r_sum_o;
  assign cout   = r_cout_o;

  // Partial sum with the current nibble merged in.
  always_comb begin
    w_sum_nxt = r_sum;
    w_sum_nxt[4*r_idx +: 4] = add_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    add_a       = 4'd0;
    add_b       = 4'd0;
    add_cin     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        add_a   = r_a[4*r_idx +: 4];
        add_b   = r_b[4*r_idx +: 4];
        add_cin = r_c;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= 1'b0;
      r_sum    <= '0;
      r_idx    <= '0;
      r_sum_o  <= '0;
      r_cout_o <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= op_a;
            // Subtract as A + ~B + 1.
            r_b   <= w_sub ? ~op_b : op_b;
            r_c   <= w_sub ? 1'b1 : op_cin;
            r_sum <= '0;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          r_sum <= w_sum_nxt;
          r_c   <= add_cout;
          if (w_last) begin
            r_idx    <= '0;
            r_sum_o  <= w_sum_nxt;
            r_cout_o <= add_cout;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (NIBBLES=4).
// Models the external 4-bit adder and checks results against plain arithmetic.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_cin = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic         op_sub = 1'b0;
`endif
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Team combinational 4-bit adder.
  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_a(op_a),
    .op_b(op_b),
    .op_cin(op_cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .op_sub(op_sub),
`endif
    .add_a(add_a),
    .add_b(add_b),
    .add_cin(add_cin),
    .add_s(add_s),
    .add_cout(add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .busy(busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W:0] ref_op(logic [W-1:0] a, logic [W-1:0] b,
                                        logic cin, logic sub);
    logic [W:0] r;
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end
    return r;
  endfunction

  task automatic drive(logic [W-1:0] a, logic [W-1:0] b,
                       logic cin, logic sub);
    op_a   = a;
    op_b   = b;
    op_cin = cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    op_sub = sub;
`else
    if (sub) $display("note: subtract vector in add-only build");
`endif
  endtask

  // Called #1 after a posedge. Runs one op with out_ready high.
  task automatic run_op(string nm, logic [W-1:0] a, logic [W-1:0] b,
                        logic cin, logic sub, logic [W-1:0] es,
                        logic ec, bit scr);
    int lat;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    drive(a, b, cin, sub);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scr) drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      chk({nm, " timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    chk({nm, " latency"}, 32'(lat), 32'(N));
    chk({nm, " sum"}, 32'(sum), 32'(es));
    chk({nm, " cout"}, 32'(cout), 32'(ec));
    @(posedge clk);
    #1;
    chk({nm, " idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W:0] r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic ci;
    logic [W-1:0] hold_s;
    logic hold_c;
    bit ov_seen;

    tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    tbl.push_back('{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    tbl.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    tbl.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
    tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    tbl.push_back('{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1});
`endif

    // Reset state.
    #12;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst sum", {15'd0, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
             tbl[i].sub, tbl[i].s, tbl[i].c, 1'b0);

    // Backpressure: hold result for 5 cycles, in_valid ignored.
    out_ready = 1'b0;
    drive(16'h2222, 16'h1111, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    chk("bp valid", 32'(out_valid), 32'd1);
    hold_s = sum;
    hold_c = cout;
    chk("bp sum", 32'(hold_s), 32'h3333);
    for (int k = 0; k < 5; k++) begin
      drive(16'h7777, 16'h7777, 1'b1, 1'b0);
      in_valid = (k == 2);
      @(posedge clk);
      #1;
      chk($sformatf("bp hold%0d", k),
          {14'd0, in_ready, out_valid, sum}, {15'd1, hold_s});
      chk($sformatf("bp cout%0d", k), 32'(cout), 32'(hold_c));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("bp no accept", 32'(busy), 32'd0);

    // Reset mid-RUN after two nibbles.
    drive(16'hABCD, 16'h1111, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst in_ready", 32'(in_ready), 32'd1);
    chk("mrst out_valid", 32'(out_valid), 32'd0);
    chk("mrst sum", {15'd0, cout, sum}, 32'd0);
    chk("mrst adder", {23'd0, add_cin, add_b, add_a}, 32'd0);
    ov_seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      ov_seen |= out_valid;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) begin
      @(posedge clk);
      #1;
      ov_seen |= out_valid;
    end
    chk("mrst no valid", 32'(ov_seen), 32'd0);
    run_op("after rst", 16'h0001, 16'h0002, 1'b0, 1'b0,
           16'h0003, 1'b0, 1'b0);

    // Operand changes during RUN ignored.
    run_op("scramble", 16'h1234, 16'h4321, 1'b0, 1'b0,
           16'h5555, 1'b0, 1'b1);

    // Random ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom);
      r  = ref_op(a, b, ci, 1'b0);
      run_op($sformatf("rnd%0d", i), a, b, ci, 1'b0,
             r[W-1:0], r[W], (i % 4) == 0);
    end
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      r = ref_op(a, b, 1'($urandom), 1'b1);
      run_op($sformatf("rsub%0d", i), a, b, 1'($urandom), 1'b1,
             r[W-1:0], r[W], 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
